// File: rtl/crc16_pkg.sv
// Shared CRC-16 (poly 0x8005, MSB-first, init 0, no reflection/xorout) definitions
// used by both the frame generator and the frame checker.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD1,
        STREAM,
        STATUS
    } state_t;

    // One byte of CRC update, MSB of data first; the loop unrolls to 8 XOR stages.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational single-byte CRC-16 step, shared by generator and checker so both
// sides are built from identical equations.
module crc16_byte_step
    import crc16_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_next(crc_in, data);

endmodule

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 checker: strips the two trailing CRC bytes, forwards the
// payload and emits a one-cycle status pulse per frame.
module crc16_frame_checker
    import crc16_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             stat_valid,
    output logic             crc_ok,
    output logic             len_err,
    output logic [LEN_W-1:0] stat_len
);

    state_t             state;
    state_t             state_next;
    logic [15:0]        crc_r;
    logic [15:0]        crc_step;
    logic [7:0]         b0;
    logic [7:0]         b1;
    logic [LEN_W-1:0]   len_cnt;
    logic               len_err_r;
    logic               accept;
    logic               load;

    crc16_byte_step u_step (
        .crc_in  (crc_r),
        .data    (in_data),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = (state != STATUS) && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        load       = accept && (state == STREAM);
        stat_valid = (state == STATUS);
        crc_ok     = (state == STATUS) && (crc_r == 16'h0000) && !len_err_r;
        len_err    = (state == STATUS) && len_err_r;
        stat_len   = (state == STATUS) ? len_cnt : '0;
        case (state)
            IDLE:    if (accept) state_next = in_last ? STATUS : HOLD1;
            HOLD1:   if (accept) state_next = in_last ? STATUS : STREAM;
            STREAM:  if (accept && in_last) state_next = STATUS;
            STATUS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame context: running residue, two-byte delay line, payload counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_r     <= CRC16_INIT;
            b0        <= '0;
            b1        <= '0;
            len_cnt   <= '0;
            len_err_r <= 1'b0;
        end else if (state == STATUS) begin
            crc_r     <= CRC16_INIT;
            b0        <= '0;
            b1        <= '0;
            len_cnt   <= '0;
            len_err_r <= 1'b0;
        end else if (accept) begin
            crc_r <= crc_step;
            b1    <= in_data;
            if (state != IDLE) begin
                b0 <= b1;
            end
            if (in_last && (state != STREAM)) begin
                len_err_r <= 1'b1;
            end
            if (load && (len_cnt != {LEN_W{1'b1}})) begin
                len_cnt <= len_cnt + LEN_W'(1);
            end
        end
    end

    // Output register holds its byte under backpressure; a new load wins over a drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= b0;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: doc/crc16_frame_checker.md
# crc16_frame_checker

Receive-side CRC-16 checker that sits directly downstream of the byte-parallel CRC-16 generator. It accepts a byte stream with valid/ready handshaking, where each frame is payload followed by two CRC bytes, high byte first. It forwards the payload with the CRC bytes stripped and reports per-frame status: CRC pass/fail, length error, and payload length. The CRC is polynomial 0x8005 (x^16+x^15+x^2+1), MSB-first, init 0x0000, no reflection, no final XOR.

## Interface
- LEN_W, 16, width of the payload length counter.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte, MSB is the first bit on the wire.
- in_last  in  1  marks the final byte of the frame, which is the low CRC byte.
- in_ready  out  1  block can accept a byte this cycle.
- out_valid  out  1  payload byte valid.
- out_data  out  8  payload byte.
- out_last  out  1  final payload byte of the frame.
- out_ready  in  1  downstream accepts the payload byte.
- stat_valid  out  1  one-cycle status pulse.
- crc_ok  out  1  residue was zero and length was legal; valid with stat_valid.
- len_err  out  1  frame was shorter than 3 bytes; valid with stat_valid.
- stat_len  out  LEN_W  payload byte count (frame length minus 2), saturating; valid with stat_valid.

## Operation
- A byte is accepted when in_valid && in_ready.
- in_ready = (state != STATUS) && (!out_valid || out_ready). This is combinational.
- CRC register crc_r is 16 bits and is cleared at frame start. Each accepted byte updates it as crc_r <= crc16_next(crc_r, in_data).
- The CRC covers every byte of the frame, CRC bytes included. The frame is good when the final residue is 0x0000.
- A two-entry byte delay line (b0 = older, b1 = newer) strips the trailing CRC bytes.
- States:
  - IDLE: 0 bytes buffered. On accept: b1 <= byte, go to HOLD1. If in_last, go to STATUS with len_err=1.
  - HOLD1: 1 byte buffered. On accept: b0 <= b1, b1 <= byte, go to STREAM. If in_last, go to STATUS with len_err=1.
  - STREAM: 2 bytes buffered. On accept: load the output register with b0, then shift b0 <= b1, b1 <= byte.
    - If in_last, set out_last=1 on that output byte and go to STATUS.
    - Otherwise stay in STREAM.
  - STATUS: one cycle. stat_valid=1, crc_ok=(residue==0)&&!len_err, len_err, stat_len are driven. in_ready=0. Go to IDLE, clear crc_r, length counter, and the delay line.
- Length counter increments on each output byte loaded and saturates at 2^LEN_W-1. Saturation does not affect crc_ok.
- Payload is forwarded even when the CRC fails. Downstream discards based on status.
- out_valid clears on out_ready unless a new byte is loaded in the same cycle.
- Reset mid-frame: all buffered bytes are dropped, no status pulse is issued, and the block returns to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, stat_valid=0, crc_ok=0, len_err=0, stat_len=0. State is IDLE and crc_r=0.
- Payload byte k appears on out_valid in the cycle after byte k+2 is accepted. Steady-state latency is 1 cycle plus the two-byte delay.
- stat_valid is asserted exactly 1 cycle after the in_last byte is accepted. The last payload byte's out_valid goes high in the same cycle.
- Back-to-back frames cost one idle input cycle (STATUS) per frame. Throughput is otherwise 1 byte per cycle with out_ready held high.
- Backpressure: if out_valid && !out_ready, in_ready=0. The output register holds its value; no byte is dropped or duplicated.
- in_last accepted in IDLE (1-byte frame): stat_valid follows with len_err=1, crc_ok=0, stat_len=0, and no output byte.

## Structure
- Package crc16_pkg holds:
  - CRC16_POLY = 16'h8005 and CRC16_INIT = 16'h0000.
  - State enum {IDLE, HOLD1, STREAM, STATUS}.
  - Function crc16_next(crc[15:0], data[7:0]), an 8-step MSB-first unrolled update.
- The function is shared with the generator so both sides use identical equations.
- One sub-module is natural: crc16_byte_step, a combinational wrapper around crc16_next. It lets the checker and the generator instantiate the same step and allows the bench to unit-test it.

## Test plan
- Frame "123456789" (0x31..0x39) + 0xFE, 0xE8, out_ready=1 -> 9 bytes 0x31..0x39 out, out_last on 0x39; stat_valid with crc_ok=1, len_err=0, stat_len=9.
- Same frame with last byte 0xE9 -> same 9 payload bytes; crc_ok=0, len_err=0, stat_len=9.
- Frame 0x00, 0x00, 0x00 (1 payload byte) -> one output 0x00 with out_last; crc_ok=1, stat_len=1. Frame of 2 bytes 0xAA, 0xBB with in_last -> no output, len_err=1, crc_ok=0, stat_len=0.
- "123456789" frame with out_ready low for 3 cycles mid-stream -> in_ready low in those cycles; the output sequence is identical to the first case with no loss or duplication; crc_ok=1.
- Two good frames back-to-back with in_valid held high -> one STATUS gap cycle, two status pulses, both crc_ok=1, payload boundaries correct.
- rst asserted after 5 bytes of a frame, then a good frame is sent -> no status for the aborted frame; the second frame passes with crc_ok=1.
